// File: rtl/mux_arb4_pkg.sv
// Shared types and constants for the four-requester capture arbiter.
// Holds the FSM state encoding and the index/requester sizing.
package mux_arb4_pkg;

    localparam int IDX_W = 2;
    localparam int N_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin winner search over four requesters, starting just after ptr.
// Purely combinational: 0 cycles latency, no backpressure of its own.
module rr_pick4
    import mux_arb4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [IDX_W-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // after ptr is the last one written and therefore wins.
    always_comb begin
        winner = ptr;
        idx    = '0;
        any    = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux_arb4.sv
// Four-way round-robin capture arbiter with a one-word output register; optional stall timeout under MUX_ARB4_TIMEOUT_EN.
// Latency: ack in the request cycle, out_valid one cycle later; a transfer and a new capture can share a cycle.
// Backpressure: out_ready low freezes the held word and blocks ack (or drops it after TIMEOUT_CYC stalls).
module mux_arb4
    import mux_arb4_pkg::*;
#(
    parameter int DATA_W      = 2,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [DATA_W-1:0]    x0,
    input  logic [DATA_W-1:0]    x1,
    input  logic [DATA_W-1:0]    x2,
    input  logic [DATA_W-1:0]    x3,
    output logic [N_REQ-1:0]     ack,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [IDX_W-1:0]     out_sel,
    output logic                 drop
);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  winner;
    logic              any;
    logic              cap_en;
    logic              cap;
    logic              timeout;
    logic              idle_blk;
    logic [DATA_W-1:0] sel_data;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        sel_data = x0;
        unique case (winner)
            2'd0: sel_data = x0;
            2'd1: sel_data = x1;
            2'd2: sel_data = x2;
            2'd3: sel_data = x3;
            default: sel_data = x0;
        endcase
    end

`ifdef MUX_ARB4_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] stall_cnt;
    logic       drop_q;

    // Fires on the TIMEOUT_CYC-th consecutive stalled HOLD cycle.
    assign timeout  = (state == HOLD) && !out_ready && (stall_cnt == TMO_LAST);
    assign idle_blk = drop_q;
    assign drop     = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= timeout;
            if ((state == HOLD) && !out_ready && !timeout) begin
                stall_cnt <= stall_cnt + 8'd1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end
`else
    localparam int unused_tmo = TIMEOUT_CYC;

    assign timeout  = 1'b0;
    assign idle_blk = 1'b0;
    assign drop     = 1'b0;
`endif

    // The drop cycle is IDLE but must not capture, hence idle_blk.
    always_comb begin
        cap_en    = (state == IDLE) ? !idle_blk : out_ready;
        cap       = cap_en && any && !rst;
        ack       = cap ? (N_REQ'(1) << winner) : '0;
        state_nxt = state;
        if (cap) begin
            state_nxt = HOLD;
        end else if ((state == HOLD) && (out_ready || timeout)) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= 2'd3;
        end else begin
            state <= state_nxt;
            if (cap) begin
                out_data <= sel_data;
                out_sel  <= winner;
                ptr      <= winner;
            end
        end
    end

    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_mux_arb4.sv
// Randomised and directed checks of mux_arb4 against a cycle-level reference model.
module tb_mux_arb4;

    localparam int DW  = 2;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] x0, x1, x2, x3;
    logic [3:0]    ack;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          drop;

    mux_arb4 #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

`ifdef MUX_ARB4_TIMEOUT_EN
    bit tmo_en = 1'b1;
`else
    bit tmo_en = 1'b0;
`endif

    // Reference model: what the consumer sees, in plain integers.
    int m_valid, m_data, m_sel, m_ptr, m_stall, m_drop;
    logic [31:0] obs_ack, obs_sel, obs_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 3; m_stall = 0; m_drop = 0;
    endtask

    // One clock cycle: drive, compare at negedge, advance the model, return just after posedge.
    task automatic step(input logic [3:0] r, input logic rdy,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        int w, ea;
        bit en;
        int dv[4];
        req = r; out_ready = rdy; x0 = d0; x1 = d1; x2 = d2; x3 = d3;
        dv[0] = int'(d0); dv[1] = int'(d1); dv[2] = int'(d2); dv[3] = int'(d3);
        @(negedge clk);
        en = (m_valid == 0) ? (m_drop == 0) : rdy;
        w  = pick(r, m_ptr);
        ea = (en && w >= 0) ? (1 << w) : 0;
        check("ack",       ack,       ea);
        check("out_valid", out_valid, m_valid);
        check("out_data",  out_data,  m_data);
        check("out_sel",   out_sel,   m_sel);
        check("drop",      drop,      m_drop);
        obs_ack = ack; obs_sel = out_sel; obs_drop = drop;
        if (ea != 0) begin
            m_valid = 1; m_data = dv[w]; m_sel = w; m_ptr = w; m_stall = 0; m_drop = 0;
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0; m_stall = 0; m_drop = 0;
        end else if (m_valid != 0) begin
            m_drop = 0;
            if (tmo_en) begin
                m_stall++;
                if (m_stall == TMO) begin
                    m_valid = 0; m_drop = 1; m_stall = 0;
                end
            end
        end else begin
            m_drop = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
    endtask

    initial begin
        int exp_ack_seq[5];
        exp_ack_seq[0] = 1; exp_ack_seq[1] = 2; exp_ack_seq[2] = 4;
        exp_ack_seq[3] = 8; exp_ack_seq[4] = 1;
        obs_ack = '0; obs_sel = '0; obs_drop = '0;

        // Reset state, with requests pending to show ack is held off.
        rst = 1'b1; req = 4'b1001; out_ready = 1'b1;
        x0 = 2'd3; x1 = 2'd2; x2 = 2'd1; x3 = 2'd3;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data,  0);
        check("rst_sel",   out_sel,   0);
        check("rst_ack",   ack,       0);
        check("rst_drop",  drop,      0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Saturated requests rotate 0,1,2,3,0 with out_sel trailing by one cycle.
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
            if (i < 5) check("rr_ack_seq", obs_ack, exp_ack_seq[i]);
            if (i > 0) check("rr_sel_seq", obs_sel, (i - 1) % 4);
        end

        // Single requester held under backpressure, then released.
        drain();
        step(4'b0100, 1'b0, 2'd0, 2'd0, 2'b10, 2'd0);
        check("hold_ack", obs_ack, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b0, 2'd1, 2'd1, 2'd1, 2'd1);
            check("hold_data", out_data, 2'b10);
            check("hold_sel",  out_sel,  2);
        end
        step(4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        step(4'b0000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        check("hold_idle", out_valid, 0);

        // Back-to-back: transfer of requester 1 and capture of requester 0 together.
        drain();
        step(4'b0010, 1'b1, 2'd2, 2'd1, 2'd0, 2'd0);
        check("b2b_first", obs_ack, 4'b0010);
        step(4'b0011, 1'b1, 2'd2, 2'd1, 2'd0, 2'd0);
        check("b2b_ack", obs_ack, 4'b0001);
        step(4'b0000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        check("b2b_valid", out_valid, 1);
        check("b2b_sel",   out_sel,   0);

        // Long stall: timeout build drops after TMO stalls, otherwise the word is held.
        drain();
        step(4'b0100, 1'b1, 2'd0, 2'd0, 2'd3, 2'd0);
        for (int i = 0; i < TMO; i++) step(4'b0000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        step(4'b1011, 1'b0, 2'd1, 2'd2, 2'd3, 2'd1);
        if (tmo_en) begin
            check("tmo_drop",    obs_drop, 1);
            check("tmo_noack",   obs_ack,  0);
            step(4'b1011, 1'b0, 2'd1, 2'd2, 2'd3, 2'd1);
            check("tmo_next",    obs_ack,  4'b1000);
        end else begin
            check("notmo_drop",  obs_drop, 0);
            check("notmo_valid", out_valid, 1);
            step(4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
        end

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end

        // Asynchronous reset in the middle of a HOLD.
        drain();
        step(4'b0010, 1'b0, 2'd0, 2'd3, 2'd0, 2'd0);
        step(4'b1001, 1'b0, 2'd3, 2'd3, 2'd3, 2'd3);
        check("arst_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data",  out_data,  0);
        check("arst_ack",   ack,       0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(4'b1001, 1'b1, 2'd2, 2'd0, 2'd0, 2'd1);
        check("arst_first", obs_ack, 4'b0001);
        step(4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
